// File: rtl/fmap_collector.sv
// Deserialising input buffer for the pooling stage: gathers N pixels into one flat frame.
// Optional feature: define FMAP_RELU_EN to clamp negative pixels to zero at capture.

module fmap_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int InputH     = 28,
  parameter int InputW     = 28,
  parameter int Depth      = 1,
  localparam int N         = InputH * InputW * Depth,
  localparam int CW        = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [0:N*DATA_WIDTH-1] frame_out,
  output logic                    frame_valid,
  input  logic                    frame_ack
);

  // state | meaning
  // FILL  | accepting pixels, count = index of next slot to write
  // FULL  | frame complete and frozen, waiting for frame_ack

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                  state;
  logic [CW-1:0]           count;
  logic [DATA_WIDTH-1:0]   stored;

`ifdef FMAP_RELU_EN
  assign stored = pix_in[DATA_WIDTH-1] ? '0 : pix_in;
`else
  assign stored = pix_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      count       <= '0;
      pix_ready   <= 1'b1;
      frame_valid <= 1'b0;
      frame_out   <= '0;
    end else begin
      case (state)
        FILL: begin
          // pix_ready is always high in FILL, so a transfer is just pix_valid
          if (pix_valid) begin
            frame_out[int'(count)*DATA_WIDTH +: DATA_WIDTH] <= stored;
            if (count == LAST) begin
              count       <= '0;
              state       <= FULL;
              pix_ready   <= 1'b0;
              frame_valid <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        FULL: begin
          if (frame_ack) begin
            state       <= FILL;
            pix_ready   <= 1'b1;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          count       <= '0;
          pix_ready   <= 1'b1;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
